set_region_counter: RTL and testbench

SET_REGION_COUNTER -- requirements
Module: set_region_counter

---
 rtl/set_region_counter_pkg.sv | 25 ++
 rtl/set_region_counter_circle_member.sv | 46 ++++
 rtl/set_region_counter.sv | 118 +++++++++++
 tb/tb_set_region_counter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/set_region_counter_pkg.sv
// Shared types and constants for the set-region counter: FSM states,
// default geometry and the legacy truth-table encodings.
package set_region_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_GRID  = 8;
  localparam int DEF_NCIRC = 3;
  localparam int DEF_CW    = 4;

  // Cycles spent flushing the membership pipeline after the last point.
  localparam int DRAIN_CYCLES = 3;

  // Legacy truth tables for three circles (idx bit i = membership of circle i).
  localparam logic [7:0] FUNC_A            = 8'hAA;
  localparam logic [7:0] FUNC_A_AND_B      = 8'h88;
  localparam logic [7:0] FUNC_A_XOR_B      = 8'h66;
  localparam logic [7:0] FUNC_TWO_OF_THREE = 8'h68;

endpackage

// File: rtl/set_region_counter_circle_member.sv
// Three-stage test of one grid point against one circle:
// offsets, squares, then the full-precision radius comparison.
module circle_member #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] cx,
  input  logic [CW-1:0] cy,
  input  logic [CW-1:0] r,
  output logic          m
);

  logic signed [CW:0]     dx;
  logic signed [CW:0]     dy;
  logic        [2*CW+1:0] dx2;
  logic        [2*CW+1:0] dy2;
  logic        [2*CW+2:0] dist2;
  logic        [2*CW+2:0] r_ext;
  logic        [2*CW+2:0] r2;

  // Squares and sums are kept wide enough that nothing is ever truncated,
  // so large radii and far-off centres compare exactly.
  assign dist2 = {1'b0, dx2} + {1'b0, dy2};
  assign r_ext = {{(CW+3){1'b0}}, r};
  assign r2    = r_ext * r_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx  <= '0;
      dy  <= '0;
      dx2 <= '0;
      dy2 <= '0;
      m   <= 1'b0;
    end else begin
      dx  <= $signed({1'b0, x}) - $signed({1'b0, cx});
      dy  <= $signed({1'b0, y}) - $signed({1'b0, cy});
      dx2 <= dx * dx;
      dy2 <= dy * dy;
      m   <= (dist2 <= r2);
    end
  end

endmodule

// File: rtl/set_region_counter.sv
// Scans every point of a GRID x GRID lattice and counts the points whose
// circle-membership pattern selects a 1 in the captured truth table.
module set_region_counter
  import set_region_pkg::*;
#(
  parameter  int GRID  = DEF_GRID,
  parameter  int NCIRC = DEF_NCIRC,
  parameter  int CW    = DEF_CW,
  localparam int KW    = $clog2(GRID * GRID + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [2*CW*NCIRC-1:0]   central,
  input  logic [CW*NCIRC-1:0]     radius,
  input  logic [(1<<NCIRC)-1:0]   func,
  output logic                    busy,
  output logic                    valid,
  output logic [KW-1:0]           candidate
);

  state_t                  state;
  state_t                  state_next;
  logic [CW-1:0]           x;
  logic [CW-1:0]           y;
  logic [1:0]              drain_cnt;
  logic [2*CW*NCIRC-1:0]   central_q;
  logic [CW*NCIRC-1:0]     radius_q;
  logic [(1<<NCIRC)-1:0]   func_q;
  logic [2:0]              pipe_v;
  logic [NCIRC-1:0]        member;
  logic                    accept;
  logic                    scan_last;

  assign accept    = (state == IDLE) && en;
  assign scan_last = (state == SCAN) && (x == CW'(GRID)) && (y == CW'(GRID));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    valid      = 1'b0;
    case (state)
      IDLE:  if (en) state_next = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (scan_last) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 2'(DRAIN_CYCLES - 1)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        valid      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // pipe_v tracks which membership results belong to real points; a point
  // issued in SCAN reaches the accumulator three cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= CW'(1);
      y         <= CW'(1);
      drain_cnt <= '0;
      central_q <= '0;
      radius_q  <= '0;
      func_q    <= '0;
      pipe_v    <= '0;
      candidate <= '0;
    end else begin
      pipe_v    <= {pipe_v[1:0], state == SCAN};
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (accept) begin
        central_q <= central;
        radius_q  <= radius;
        func_q    <= func;
        candidate <= '0;
        x         <= CW'(1);
        y         <= CW'(1);
      end else begin
        if (state == SCAN) begin
          if (x == CW'(GRID)) begin
            x <= CW'(1);
            y <= y + CW'(1);
          end else begin
            x <= x + CW'(1);
          end
        end
        if (pipe_v[2] && func_q[member]) candidate <= candidate + KW'(1);
      end
    end
  end

  // Circle 0 sits in the MSBs of the packed buses but drives idx bit 0.
  for (genvar i = 0; i < NCIRC; i++) begin : g_member
    circle_member #(
      .CW(CW)
    ) u_member (
      .clk(clk),
      .rst(rst),
      .x  (x),
      .y  (y),
      .cx (central_q[(NCIRC-1-i)*2*CW + CW +: CW]),
      .cy (central_q[(NCIRC-1-i)*2*CW +: CW]),
      .r  (radius_q[(NCIRC-1-i)*CW +: CW]),
      .m  (member[i])
    );
  end

endmodule

// File: tb/tb_set_region_counter.sv
// Directed bench for set_region_counter: table of circle configurations with
// hand-counted results, plus reset-abort and held-enable sequences.
module tb_set_region_counter;
  import set_region_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [7:0]  func;
  logic        busy;
  logic        valid;
  logic [6:0]  candidate;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [23:0] central;
    logic [11:0] radius;
    logic [7:0]  func;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[11];

  set_region_counter dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .central  (central),
    .radius   (radius),
    .func     (func),
    .busy     (busy),
    .valid    (valid),
    .candidate(candidate)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] cen(int x0, int y0, int x1, int y1, int x2, int y2);
    return {4'(x0), 4'(y0), 4'(x1), 4'(y1), 4'(x2), 4'(y2)};
  endfunction

  function automatic logic [11:0] rad(int r0, int r1, int r2);
    return {4'(r0), 4'(r1), 4'(r2)};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One full command; stray en with scrambled inputs is thrown in mid-scan.
  task automatic apply_stimulus(input vec_t v);
    int valid_at  = -1;
    int busy_cnt  = 0;
    int valid_cnt = 0;
    @(posedge clk); #1;
    central = v.central;
    radius  = v.radius;
    func    = v.func;
    en      = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (busy) busy_cnt++;
      if (valid) begin
        valid_cnt++;
        if (valid_at < 0) valid_at = n;
        check_output({v.name, "_cand_at_valid"}, 32'(candidate), 32'(v.exp_cnt));
      end
      if (n == 10) begin
        central = ~v.central;
        radius  = ~v.radius;
        func    = ~v.func;
        en      = 1'b1;
      end else begin
        en = 1'b0;
      end
      @(posedge clk); #1;
    end
    check_output({v.name, "_valid_cycle"}, 32'(valid_at), 32'd68);
    check_output({v.name, "_valid_count"}, 32'(valid_cnt), 32'd1);
    check_output({v.name, "_busy_cycles"}, 32'(busy_cnt), 32'd68);
    check_output({v.name, "_cand_hold"}, 32'(candidate), 32'(v.exp_cnt));
  endtask

  initial begin
    int v1;
    int v2;

    vecs[0]  = '{"disk_r2",   cen(4,4,0,0,0,0), rad(2,0,0),   FUNC_A,            13};
    vecs[1]  = '{"r0_corner", cen(1,1,0,0,0,0), rad(0,0,0),   FUNC_A,            1};
    vecs[2]  = '{"r15_full",  cen(1,1,0,0,0,0), rad(15,0,0),  FUNC_A,            64};
    vecs[3]  = '{"r9_prec",   cen(1,1,0,0,0,0), rad(9,0,0),   FUNC_A,            61};
    vecs[4]  = '{"a_and_b",   cen(3,3,5,3,0,0), rad(2,2,0),   FUNC_A_AND_B,      5};
    vecs[5]  = '{"a_xor_b",   cen(3,3,5,3,0,0), rad(2,2,0),   FUNC_A_XOR_B,      16};
    vecs[6]  = '{"off_grid",  cen(0,4,0,0,0,0), rad(2,0,0),   FUNC_A,            4};
    vecs[7]  = '{"circle2",   cen(0,0,0,0,8,8), rad(0,0,1),   8'hF0,             3};
    vecs[8]  = '{"func_zero", cen(4,4,0,0,0,0), rad(2,0,0),   8'h00,             0};
    vecs[9]  = '{"func_all",  cen(4,4,0,0,0,0), rad(2,0,0),   8'hFF,             64};
    vecs[10] = '{"two_of_3",  cen(3,3,5,3,4,5), rad(2,2,1),   FUNC_TWO_OF_THREE, 6};

    rst = 1'b1; en = 1'b0; central = '0; radius = '0; func = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy",  32'(busy), 32'd0);
    check_output("rst_valid", 32'(valid), 32'd0);
    check_output("rst_cand",  32'(candidate), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("idle_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Abort a scan with rst, then confirm the next command is unaffected.
    @(posedge clk); #1;
    central = cen(1,1,1,1,1,1);
    radius  = rad(15,15,15);
    func    = 8'hFF;
    en      = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check_output("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_output("abort_busy",  32'(busy), 32'd0);
    check_output("abort_valid", 32'(valid), 32'd0);
    check_output("abort_cand",  32'(candidate), 32'd0);
    @(posedge clk); #1;
    check_output("abort_cand_next", 32'(candidate), 32'd0);
    rst = 1'b0;
    vecs[0].name = "post_abort";
    apply_stimulus(vecs[0]);

    // Hold en high: the second accept happens the cycle after DONE.
    @(posedge clk); #1;
    central = vecs[0].central;
    radius  = vecs[0].radius;
    func    = vecs[0].func;
    en      = 1'b1;
    v1 = -1;
    v2 = -1;
    @(posedge clk); #1;
    for (int n = 1; n <= 250; n++) begin
      if (valid) begin
        check_output("held_cand", 32'(candidate), 32'd13);
        if (v1 < 0) v1 = n;
        else if (v2 < 0) begin
          v2 = n;
          en = 1'b0;
        end
      end
      if (v2 > 0 && n > v2 + 3) break;
      @(posedge clk); #1;
    end
    en = 1'b0;
    check_output("held_first_valid", 32'(v1), 32'd68);
    check_output("held_spacing", (v2 > 0) ? 32'(v2 - v1) : 32'hFFFF_FFFF, 32'd69);
    check_output("held_idle_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
